// File: rtl/instruction_loader.sv
// instruction_loader: receives a program as a byte stream and writes it into
// the instruction RAM as 32-bit words (MSB first). Stream = count byte,
// N words, then an XOR checksum byte. The CPU is held in reset while a load
// is in progress and stays held if the checksum does not match.
module instruction_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256   // must equal 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  // Remaining-word counter is one bit wider so a count byte of 0 can mean DEPTH.
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      remaining_reg, remaining_next;
  logic [1:0]            index_reg, index_next;
  logic [7:0]            checksum_reg, checksum_next;
  logic [31:0]           word_reg, word_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]           mem_wdata_reg, mem_wdata_next;

  // State and datapath registers; reset returns to IDLE with everything cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      index_reg     <= '0;
      checksum_reg  <= '0;
      word_reg      <= '0;
      addr_reg      <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      index_reg     <= index_next;
      checksum_reg  <= checksum_next;
      word_reg      <= word_next;
      addr_reg      <= addr_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  // Write port holds the last written address/data between writes.
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    index_next     = index_reg;
    checksum_next  = checksum_reg;
    word_next      = word_reg;
    addr_next      = addr_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    byte_ready     = 1'b0;
    mem_we         = 1'b0;
    cpu_hold       = 1'b0;
    busy           = 1'b0;
    load_done      = 1'b0;
    load_error     = 1'b0;

    // Output decode depends only on the current state.
    case (state_reg)
      COUNT, DATA, CHECK: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        mem_we   = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
      end
      DONE:    load_done = 1'b1;
      ERROR: begin
        load_error = 1'b1;
        cpu_hold   = 1'b1;
      end
      default: ;
    endcase

    // load_start restarts from any state and takes priority over a byte
    // arriving in the same cycle; a WRITE in progress still completes.
    if (load_start) begin
      state_next     = COUNT;
      remaining_next = '0;
      index_next     = '0;
      checksum_next  = '0;
      word_next      = '0;
      addr_next      = '0;
    end else begin
      case (state_reg)
        COUNT: begin
          if (byte_valid) begin
            remaining_next = (byte_data == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(byte_data);
            checksum_next  = checksum_reg ^ byte_data;
            index_next     = '0;
            state_next     = DATA;
          end
        end
        DATA: begin
          if (byte_valid) begin
            word_next     = {word_reg[23:0], byte_data};
            checksum_next = checksum_reg ^ byte_data;
            index_next    = index_reg + 2'd1;
            if (index_reg == 2'd3) begin
              // Latch the write port now so mem_we lines up with WRITE.
              mem_addr_next  = addr_reg;
              mem_wdata_next = {word_reg[23:0], byte_data};
              state_next     = WRITE;
            end
          end
        end
        WRITE: begin
          addr_next      = addr_reg + ADDR_WIDTH'(1);
          remaining_next = remaining_reg - CNT_W'(1);
          state_next     = (remaining_reg == CNT_W'(1)) ? CHECK : DATA;
        end
        CHECK: begin
          if (byte_valid) begin
            state_next = (byte_data == checksum_reg) ? DONE : ERROR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader.
module tb_instruction_loader;

  logic        clock;
  logic        reset;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        load_done;
  logic        load_error;

  int tests = 0;
  int fails = 0;

  instruction_loader #(.ADDR_WIDTH(8), .DEPTH(256)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shadow of the RAM plus a log of every write address, sampled mid-cycle.
  logic [31:0] tbmem [0:255];
  logic [7:0]  wr_addrs [$];
  int          overlap = 0;

  always @(negedge clock) begin
    if (mem_we) begin
      tbmem[mem_addr] <= mem_wdata;
      wr_addrs.push_back(mem_addr);
      if (byte_ready) overlap <= overlap + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Present a byte (after 'gaps' idle cycles) and return 1 ns after the edge
  // that accepted it. byte_valid is left high.
  task automatic send_byte(input logic [7:0] b, input int gaps);
    bit ok;
    for (int g = 0; g < gaps; g++) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      @(posedge clock);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clock);
      if (byte_ready) ok = 1'b1;
      @(posedge clock);
      #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $error("FAIL send_timeout: byte %h not accepted, observed ready 0 expected 1", b);
    end
  endtask

  task automatic pulse_start();
    byte_valid = 1'b0;
    load_start = 1'b1;
    @(posedge clock);
    #1;
    load_start = 1'b0;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int          base;
    int          bad;
    logic [31:0] w;
    logic [7:0]  iv;
    logic [7:0]  stream [0:8];

    reset      = 1'b1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // ---- reset state ----
    #3;
    check("rst_byte_ready", 32'(byte_ready), 0);
    check("rst_mem_we",     32'(mem_we),     0);
    check("rst_mem_addr",   32'(mem_addr),   0);
    check("rst_mem_wdata",  mem_wdata,       0);
    check("rst_cpu_hold",   32'(cpu_hold),   0);
    check("rst_busy",       32'(busy),       0);
    check("rst_done",       32'(load_done),  0);
    check("rst_error",      32'(load_error), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    $display("[TB] reset released");

    // ---- good 2-word load ----
    stream = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    base = wr_addrs.size();
    pulse_start();
    check("l1_hold_start", 32'(cpu_hold),   1);
    check("l1_busy_start", 32'(busy),       1);
    check("l1_ready_cnt",  32'(byte_ready), 1);
    for (int i = 0; i < 5; i++) send_byte(stream[i], 0);
    // Cycle right after the 4th data byte is the WRITE cycle.
    check("l1_we_w0",    32'(mem_we),     1);
    check("l1_ready_w0", 32'(byte_ready), 0);
    check("l1_addr_w0",  32'(mem_addr),   0);
    check("l1_data_w0",  mem_wdata,       32'h12345678);
    for (int i = 5; i < 9; i++) send_byte(stream[i], 0);
    send_byte(8'h0A, 0);
    check("l1_done",  32'(load_done),  1);
    check("l1_error", 32'(load_error), 0);
    check("l1_hold",  32'(cpu_hold),   0);
    check("l1_busy",  32'(busy),       0);
    idle(3);
    check("l1_nwrites", 32'(wr_addrs.size() - base), 2);
    check("l1_mem0",    tbmem[0], 32'h12345678);
    check("l1_mem1",    tbmem[1], 32'hA5A5A5A5);
    check("l1_done_hold", 32'(load_done), 1);
    $display("[TB] good load: writes=%0d done=%0d", wr_addrs.size() - base, load_done);

    // ---- bad checksum ----
    base = wr_addrs.size();
    pulse_start();
    check("l2_done_clr", 32'(load_done), 0);
    for (int i = 0; i < 9; i++) send_byte(stream[i], 0);
    send_byte(8'h0B, 0);
    idle(2);
    check("l2_error",   32'(load_error), 1);
    check("l2_done",    32'(load_done),  0);
    check("l2_hold",    32'(cpu_hold),   1);
    check("l2_busy",    32'(busy),       0);
    check("l2_nwrites", 32'(wr_addrs.size() - base), 2);
    $display("[TB] bad checksum: writes=%0d error=%0d", wr_addrs.size() - base, load_error);

    // ---- full-depth load (count 00); checksum of this pattern is 00 ----
    base = wr_addrs.size();
    pulse_start();
    check("l3_err_clr", 32'(load_error), 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      iv = i[7:0];
      w  = {iv, ~iv, 8'hA0, 8'h5A};
      send_byte(w[31:24], 0);
      send_byte(w[23:16], 0);
      send_byte(w[15:8], 0);
      send_byte(w[7:0], 0);
    end
    send_byte(8'h00, 0);
    idle(5);
    check("l3_nwrites", 32'(wr_addrs.size() - base), 256);
    bad = 0;
    for (int i = 0; i < 256 && (base + i) < wr_addrs.size(); i++)
      if (wr_addrs[base + i] !== i[7:0]) bad++;
    check("l3_addr_order", 32'(bad), 0);
    check("l3_mem0",   tbmem[0],   32'h00FFA05A);
    check("l3_mem255", tbmem[255], 32'hFF00A05A);
    check("l3_done",   32'(load_done), 1);
    check("l3_hold",   32'(cpu_hold),  0);
    $display("[TB] full-depth load: writes=%0d done=%0d", wr_addrs.size() - base, load_done);

    // ---- back-pressure / random gaps; checksum EC ----
    stream = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    base = wr_addrs.size();
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(stream[i], int'($urandom_range(0, 2)));
    send_byte(8'hCA, int'($urandom_range(0, 2)));
    send_byte(8'hFE, int'($urandom_range(0, 2)));
    send_byte(8'hF0, int'($urandom_range(0, 2)));
    send_byte(8'h0D, int'($urandom_range(0, 2)));
    send_byte(8'hEC, int'($urandom_range(0, 2)));
    idle(3);
    check("l4_nwrites", 32'(wr_addrs.size() - base), 3);
    check("l4_mem0",    tbmem[0], 32'hDEADBEEF);
    check("l4_mem1",    tbmem[1], 32'h01020304);
    check("l4_mem2",    tbmem[2], 32'hCAFEF00D);
    check("l4_done",    32'(load_done), 1);
    check("l4_overlap", 32'(overlap), 0);
    $display("[TB] back-pressure load: writes=%0d done=%0d", wr_addrs.size() - base, load_done);

    // ---- abort after 5 data bytes, then fresh 1-word load (checksum 09) ----
    base = wr_addrs.size();
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    pulse_start();
    check("l5_busy_abort",  32'(busy),       1);
    check("l5_hold_abort",  32'(cpu_hold),   1);
    check("l5_ready_abort", 32'(byte_ready), 1);
    send_byte(8'h01, 0);
    send_byte(8'h9A, 0);
    send_byte(8'hBC, 0);
    send_byte(8'hDE, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h09, 0);
    idle(3);
    check("l5_nwrites", 32'(wr_addrs.size() - base), 2);
    check("l5_last_addr", 32'(wr_addrs[wr_addrs.size() - 1]), 0);
    check("l5_mem0",  tbmem[0], 32'h9ABCDEF0);
    check("l5_done",  32'(load_done),  1);
    check("l5_error", 32'(load_error), 0);
    $display("[TB] abort/restart: writes=%0d done=%0d", wr_addrs.size() - base, load_done);

    // ---- async reset mid-DATA ----
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    check("l6_busy_pre", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check("l6_busy",      32'(busy),       0);
    check("l6_hold",      32'(cpu_hold),   0);
    check("l6_ready",     32'(byte_ready), 0);
    check("l6_we",        32'(mem_we),     0);
    check("l6_wdata",     mem_wdata,       0);
    check("l6_addr",      32'(mem_addr),   0);
    base = wr_addrs.size();
    @(negedge clock);
    reset = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h03;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
    end
    byte_valid = 1'b0;
    check("l6_nwrites", 32'(wr_addrs.size() - base), 0);
    check("l6_idle_busy",  32'(busy),       0);
    check("l6_idle_ready", 32'(byte_ready), 0);
    $display("[TB] async reset mid-DATA: writes after=%0d busy=%0d", wr_addrs.size() - base, busy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
